// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pipe_pkg;

  // Sequencer states; encoding is fixed so that waveforms and debug logic agree.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EXC      = 2'd2
  } state_t;

  // Architectural zero register: writes to it are discarded, so it never forwards data.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard sequencer.
// Latency: n/a (wires only).
// Backpressure: stall/bubble outputs are the backpressure into each pipeline register.
interface pipe_hazard_ctrl_if;
  import mips_pipe_pkg::*;

  // Hazard-relevant status reported by the datapath
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic       i_ex_memread;
  logic [4:0] i_ex_regaddrw;
  logic       i_ex_branch_taken;
  logic       i_mem_req;
  logic       i_mem_ack;
  logic       i_mem_overflow;

  // Per pipeline register hold / clear controls
  logic o_pc_stall;
  logic o_ifid_stall;
  logic o_idex_stall;
  logic o_exmem_stall;
  logic o_memwb_stall;
  logic o_ifid_bubble;
  logic o_idex_bubble;
  logic o_exmem_bubble;
  logic o_memwb_bubble;

  // Sequencer side: consumes status, drives the controls
  modport master (
    input  i_id_rs, i_id_rt, i_ex_memread, i_ex_regaddrw, i_ex_branch_taken,
    input  i_mem_req, i_mem_ack, i_mem_overflow,
    output o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall, o_memwb_stall,
    output o_ifid_bubble, o_idex_bubble, o_exmem_bubble, o_memwb_bubble
  );

  // Datapath side: reports status, obeys the controls
  modport slave (
    output i_id_rs, i_id_rt, i_ex_memread, i_ex_regaddrw, i_ex_branch_taken,
    output i_mem_req, i_mem_ack, i_mem_overflow,
    input  o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall, o_memwb_stall,
    input  o_ifid_bubble, o_idex_bubble, o_exmem_bubble, o_memwb_bubble
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the sequencer's stall decision.
module hazard_detect
  import mips_pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_regaddrw,
  output logic       lu_hazard
);

  // A load whose destination is a live (non-zero) register read by the ID instruction
  assign lu_hazard = ex_memread
                  && (ex_regaddrw != REG_ZERO)
                  && ((ex_regaddrw == id_rs) || (ex_regaddrw == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/bubble controls for load-use, branch, memory wait/timeout, overflow.
// Latency: stall/bubble combinational same cycle; o_pc_exc and o_bus_err registered (1 cycle).
// Backpressure: memory wait holds PC..EX/MEM; optional perf counters under PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 16
) (
  input  logic                clk,
  input  logic                nrst,
  pipe_hazard_ctrl_if.master  pipe,
  output logic                o_pc_exc,
  output logic                o_bus_err,
  output logic [31:0]         o_perf_stall,
  output logic [31:0]         o_perf_flush
);

  state_t            state;
  state_t            state_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TMO_W-1:0]  cnt_nxt;
  logic              lu_hazard;

  logic pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble;

  hazard_detect u_hazard_detect (
    .id_rs       (pipe.i_id_rs),
    .id_rt       (pipe.i_id_rt),
    .ex_memread  (pipe.i_ex_memread),
    .ex_regaddrw (pipe.i_ex_regaddrw),
    .lu_hazard   (lu_hazard)
  );

  // Event decode, already resolved against the priority order
  logic in_run, in_wait, in_exc;
  logic run_pending;   // new access seen in RUN that will not finish this cycle
  logic free;          // cycle where ordinary events (overflow/branch/load-use) are evaluated
  logic ev_hold, ev_tmo, ev_ovf, ev_br, ev_lu;

  assign in_run      = (state == RUN);
  assign in_wait     = (state == MEM_WAIT);
  assign in_exc      = (state == EXC);
  assign run_pending = pipe.i_mem_req && !pipe.i_mem_ack;
  // The ack cycle of a wait behaves like a RUN cycle with no access pending
  assign free        = (in_run && !run_pending) || (in_wait && pipe.i_mem_ack);
  assign ev_tmo      = in_wait && !pipe.i_mem_ack && (tmo_cnt >= TMO_W'(MEM_TIMEOUT));
  assign ev_hold     = (in_run && run_pending) || (in_wait && !pipe.i_mem_ack && !ev_tmo);
  assign ev_ovf      = free && pipe.i_mem_overflow;
  assign ev_br       = free && !pipe.i_mem_overflow && pipe.i_ex_branch_taken;
  // Branch squashes the wrong-path ID instruction, so its load-use is moot
  assign ev_lu       = free && !pipe.i_mem_overflow && !pipe.i_ex_branch_taken && lu_hazard;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state and next timeout count
  always_comb begin
    state_nxt = RUN;
    cnt_nxt   = '0;
    if (ev_ovf || ev_tmo) begin
      state_nxt = EXC;
    end else if (ev_hold) begin
      state_nxt = MEM_WAIT;
      cnt_nxt   = in_run ? TMO_W'(1) : tmo_cnt + 1'b1;
    end
  end

  // Stall/bubble decode; stall always wins over bubble on the same register
  always_comb begin
    pc_stall     = ev_hold || ev_lu;
    ifid_stall   = ev_hold || ev_lu;
    idex_stall   = ev_hold;
    exmem_stall  = ev_hold;
    memwb_stall  = 1'b0;
    ifid_bubble  = (ev_ovf || ev_tmo || in_exc || ev_br) && !ifid_stall;
    idex_bubble  = (ev_ovf || ev_tmo || in_exc || ev_br || ev_lu) && !idex_stall;
    exmem_bubble = (ev_ovf || ev_tmo || in_exc) && !exmem_stall;
    memwb_bubble = (ev_ovf || ev_tmo || ev_hold) && !memwb_stall;
  end

  assign pipe.o_pc_stall     = pc_stall;
  assign pipe.o_ifid_stall   = ifid_stall;
  assign pipe.o_idex_stall   = idex_stall;
  assign pipe.o_exmem_stall  = exmem_stall;
  assign pipe.o_memwb_stall  = memwb_stall;
  assign pipe.o_ifid_bubble  = ifid_bubble;
  assign pipe.o_idex_bubble  = idex_bubble;
  assign pipe.o_exmem_bubble = exmem_bubble;
  assign pipe.o_memwb_bubble = memwb_bubble;

  // Timeout counter, exception vector strobe (high exactly while in EXC) and sticky bus error
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tmo_cnt   <= '0;
      o_pc_exc  <= 1'b0;
      o_bus_err <= 1'b0;
    end else begin
      tmo_cnt   <= cnt_nxt;
      o_pc_exc  <= (state_nxt == EXC);
      o_bus_err <= o_bus_err || ev_tmo;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic        flush_ev;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;

  // EXC-state clears and wait/load-use bubbles are not counted as flush events
  assign flush_ev = ev_br || ev_ovf || ev_tmo;

  // Free-running wrapping performance counters
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (pc_stall) perf_stall <= perf_stall + 32'd1;
      if (flush_ev) perf_flush <= perf_flush + 32'd1;
    end
  end

  assign o_perf_stall = perf_stall;
  assign o_perf_flush = perf_flush;
`else
  assign o_perf_stall = '0;
  assign o_perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT overridden to 4).
// Inputs change 1ns after posedge, combinational outputs sampled 3ns later.
// Registered outputs sampled 1ns after posedge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        o_pc_exc;
  logic        o_bus_err;
  logic [31:0] o_perf_stall;
  logic [31:0] o_perf_flush;

  int n_chk = 0;
  int n_err = 0;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc,ifid,idex,exmem,memwb stall, ifid,idex,exmem,memwb bubble}
  localparam logic [8:0] C_IDLE = 9'b00000_0000;
  localparam logic [8:0] C_LU   = 9'b11000_0100;
  localparam logic [8:0] C_BR   = 9'b00000_1100;
  localparam logic [8:0] C_HOLD = 9'b11110_0001;
  localparam logic [8:0] C_ALL  = 9'b00000_1111;
  localparam logic [8:0] C_EXC  = 9'b00000_1110;

  pipe_hazard_ctrl_if pif ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .TMO_W(16)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .pipe         (pif),
    .o_pc_exc     (o_pc_exc),
    .o_bus_err    (o_bus_err),
    .o_perf_stall (o_perf_stall),
    .o_perf_flush (o_perf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {23'd0, pif.o_pc_stall, pif.o_ifid_stall, pif.o_idex_stall, pif.o_exmem_stall,
            pif.o_memwb_stall, pif.o_ifid_bubble, pif.o_idex_bubble, pif.o_exmem_bubble,
            pif.o_memwb_bubble};
  endfunction

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic memread,
                        input logic [4:0] regw, input logic br, input logic req,
                        input logic ack, input logic ovf);
    pif.i_id_rs           = rs;
    pif.i_id_rt           = rt;
    pif.i_ex_memread      = memread;
    pif.i_ex_regaddrw     = regw;
    pif.i_ex_branch_taken = br;
    pif.i_mem_req         = req;
    pif.i_mem_ack         = ack;
    pif.i_mem_overflow    = ovf;
  endtask

  task automatic idle_in();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0;
    idle_in();
    #8;
    chk("rst_ctl", ctl(), {23'd0, C_IDLE});
    chk("rst_pc_exc", {31'd0, o_pc_exc}, 32'd0);
    chk("rst_bus_err", {31'd0, o_bus_err}, 32'd0);
    chk("rst_perf_stall", o_perf_stall, 32'd0);
    chk("rst_perf_flush", o_perf_flush, 32'd0);
    #4 nrst = 1'b1;
    step();
    chk("run_idle", ctl(), {23'd0, C_IDLE});

    // Load-use on rs, then on rt; lasts only while the load sits in EX
    set_in(5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    chk("lu_rs", ctl(), {23'd0, C_LU});
    step(); idle_in(); #3;
    chk("lu_gone", ctl(), {23'd0, C_IDLE});
    step();
    set_in(5'd4, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    chk("lu_rt", ctl(), {23'd0, C_LU});
    step();
    // Register zero and non-load never hazard
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    chk("lu_reg0", ctl(), {23'd0, C_IDLE});
    step();
    set_in(5'd8, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); #3;
    chk("lu_noload", ctl(), {23'd0, C_IDLE});
    step();

    // Branch together with load-use: branch wins, PC not stalled
    set_in(5'd8, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); #3;
    chk("br_lu", ctl(), {23'd0, C_BR});
    step();

    // Memory wait, ack on the 4th cycle
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #3; chk($sformatf("wait_hold%0d", i), ctl(), {23'd0, C_HOLD});
      step();
    end
    pif.i_mem_ack = 1'b1; #3;
    chk("wait_ack", ctl(), {23'd0, C_IDLE});
    step(); idle_in(); #3;
    chk("wait_back_run", ctl(), {23'd0, C_IDLE});
    step();

    // Timeout: entry cycle plus three more hold cycles, fifth cycle times out
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #3; chk($sformatf("tmo_hold%0d", i), ctl(), {23'd0, C_HOLD});
      step();
    end
    #3;
    chk("tmo_bubbles", ctl(), {23'd0, C_ALL});
    chk("tmo_bus_err_pre", {31'd0, o_bus_err}, 32'd0);
    step();
    chk("tmo_pc_exc", {31'd0, o_pc_exc}, 32'd1);
    chk("tmo_bus_err", {31'd0, o_bus_err}, 32'd1);
    chk("tmo_exc_ctl", ctl(), {23'd0, C_EXC});
    step(); idle_in(); #3;
    chk("tmo_run", ctl(), {23'd0, C_IDLE});
    chk("tmo_pc_exc_drop", {31'd0, o_pc_exc}, 32'd0);
    chk("tmo_bus_err_sticky", {31'd0, o_bus_err}, 32'd1);
    step();

    // Overflow in RUN
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); #3;
    chk("ovf_bubbles", ctl(), {23'd0, C_ALL});
    chk("ovf_pc_exc_pre", {31'd0, o_pc_exc}, 32'd0);
    step(); idle_in(); #3;
    chk("ovf_exc_ctl", ctl(), {23'd0, C_EXC});
    chk("ovf_pc_exc", {31'd0, o_pc_exc}, 32'd1);
    step();
    chk("ovf_pc_exc_once", {31'd0, o_pc_exc}, 32'd0);
    chk("ovf_run", ctl(), {23'd0, C_IDLE});

    // Overflow behind a pending access waits; processed in the ack cycle
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); #3;
    chk("ovf_pending_hold", ctl(), {23'd0, C_HOLD});
    step();
    pif.i_mem_ack = 1'b1; #3;
    chk("ovf_ack_bubbles", ctl(), {23'd0, C_ALL});
    step(); idle_in(); #3;
    chk("ovf_ack_exc", ctl(), {23'd0, C_EXC});
    chk("ovf_ack_pc_exc", {31'd0, o_pc_exc}, 32'd1);
    step();
    chk("ovf_ack_run", ctl(), {23'd0, C_IDLE});

    // Reset in the middle of a wait
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #3;
    chk("mid_hold_a", ctl(), {23'd0, C_HOLD});
    step(); #3;
    chk("mid_hold_b", ctl(), {23'd0, C_HOLD});
    chk("pre_rst_perf_stall", o_perf_stall, PERF ? 32'd11 : 32'd0);
    chk("pre_rst_perf_flush", o_perf_flush, PERF ? 32'd4 : 32'd0);
    nrst = 1'b0; idle_in(); #1;
    chk("mid_rst_ctl", ctl(), {23'd0, C_IDLE});
    chk("mid_rst_bus_err", {31'd0, o_bus_err}, 32'd0);
    chk("mid_rst_pc_exc", {31'd0, o_pc_exc}, 32'd0);
    chk("mid_rst_perf_stall", o_perf_stall, 32'd0);
    chk("mid_rst_perf_flush", o_perf_flush, 32'd0);
    #2 nrst = 1'b1;
    step();
    chk("post_rst_run", ctl(), {23'd0, C_IDLE});
    set_in(5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); idle_in(); #3;
    chk("post_rst_perf_stall", o_perf_stall, PERF ? 32'd1 : 32'd0);
    chk("post_rst_perf_flush", o_perf_flush, PERF ? 32'd1 : 32'd0);
    chk("post_rst_bus_err", {31'd0, o_bus_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
